multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM; sequences fetch/decode/execute/mem/writeback.
//  Drives the register file (RegDst, RegWrite, MemtoReg), the ALU muxes, and PC/IR/memory enables.
//  Sits between the instruction register and the datapath.
//  Stalls on a unified memory-ready handshake and counts retired instructions.
// PARAMETERS
//  STATE_W  4   width of the state register (fixed encodings below)
//  CNT_W    32  width of the retired-instruction counter
// PORTS
//  clk          in   1      clock, all state updated on posedge
//  rst          in   1      synchronous, active-high reset
//  opcode       in   6      IR[31:26]; stable outside FETCH
//  funct        in   6      IR[5:0]; passed through for ALUOp==2'b10
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory access complete this cycle
//  pc_en        out  1      PC load = PCWrite | (PCWriteCond & (zero ^ is_bne))
//  IorD         out  1      0=PC addresses memory, 1=ALUOut
//  MemRead      out  1      memory read request
//  MemWrite     out  1      memory write request
//  IRWrite      out  1      load IR
//  RegDst       out  1      0=rd, 1=rt write address
//  MemtoReg     out  1      0=ALUOut, 1=memory data
//  RegWrite     out  1      register-file write enable
//  ALUSrcA      out  1      0=PC, 1=rs
//  ALUSrcB      out  2      00=rt, 01=4, 10=sext imm, 11=sext imm<<2
//  ALUOp        out  2      00=add, 01=sub, 10=by funct, 11=by opcode (imm ops)
//  PCSource     out  2      00=ALU, 01=ALUOut, 10=jump target
//  illegal      out  1      one-cycle pulse on an undecodable opcode
//  state        out  STATE_W current state (debug)
//  retired      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6,
//   RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, ILL=12. Codes 13-15 go to FETCH next cycle.
//  Reset: state=FETCH, retired=0. Reset wins over every other event, including mid-instruction.
//  Outputs are Moore (state only) except the mem_ready-gated enables noted below.
//   Any output not listed for a state is 0.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
//   IRWrite and PCWrite assert only when mem_ready=1; on that cycle go to DECODE, else hold.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next state by opcode:
//   00->EXEC; 23/2b->MEMADR; 04/05->BRANCH; 02->JUMP; 08/0c/0d/0a->IEXEC; others->ILL.
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if lw, else MEMWR.
//  MEMRD: MemRead=1, IorD=1; hold until mem_ready, then MEMWB.
//  MEMWB: RegDst=1, MemtoReg=1, RegWrite=1 -> FETCH.
//  MEMWR: MemWrite=1, IorD=1; hold until mem_ready, then FETCH.
//   MemWrite stays high through the wait.
//  EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
//  RWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
//  IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> IWB.
//  IWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1.
//   is_bne=(opcode==05). Go to FETCH.
//  JUMP: PCWrite=1, PCSource=10 -> FETCH.
//  ILL: illegal=1 for one cycle, no writes -> FETCH (instruction skipped, not retired).
//  retired += 1 (wraps modulo 2^CNT_W) on exit from MEMWB, RWB, IWB, BRANCH, JUMP,
//   and on MEMWR exit with mem_ready=1.
//  Latency in cycles with mem_ready tied 1: R/imm=4, lw=5, sw=4, beq/bne=3, j=3.
//   Each wait cycle adds 1.
//  RegWrite is never asserted in the same cycle as MemWrite or IRWrite.
// TESTING
//  rst=1 for 2 cycles, then R-type add with mem_ready=1 ->
//   states 0,1,6,7,0; RegWrite=1 with RegDst=0 only in state 7; retired=1.
//  lw with mem_ready low for 3 cycles in MEMRD ->
//   MEMRD held 4 cycles; MEMWB asserts RegDst=1, MemtoReg=1, RegWrite=1; total 8 cycles.
//  beq with zero=1 -> pc_en=1 in BRANCH; bne with zero=1 -> pc_en=0; retired increments both times.
//  opcode=6'h3f -> DECODE then ILL; illegal pulses exactly 1 cycle;
//   no RegWrite/MemWrite; retired unchanged.
//  rst asserted during a MEMWR wait -> next cycle state=FETCH, MemWrite=0, retired=0.
//  Preload retired to 2^CNT_W-1 (force), retire one instruction -> retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
//
// Datapath -> controller : opcode, funct (IR fields), zero (ALU flag), mem_ready.
// Controller -> datapath : pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst,
//                          MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource.
//
// master: the controller side.  slave: the datapath side.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Sequences fetch / decode / execute / memory /
// writeback for R-type, lw, sw, beq, bne, j and the immediate ALU ops, stalls
// on the unified memory-ready handshake and counts retired instructions.
//
// Ports:
//   clk      clock, all state updated on posedge
//   rst      synchronous, active-high reset (state=FETCH, retired=0)
//   bus      multicycle_ctrl_if.master: IR fields, zero flag, mem_ready in;
//            datapath enables and mux selects out
//   illegal  one-cycle pulse when an undecodable opcode is skipped
//   state    current FSM state (debug)
//   retired  retired-instruction count, wraps modulo 2^CNT_W
module multicycle_ctrl #(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus,
    output logic               illegal,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   retired
);

    // State encodings are externally visible on the debug port, so they are fixed.
    localparam logic [STATE_W-1:0] FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] EXEC   = STATE_W'(6);
    localparam logic [STATE_W-1:0] RWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] BRANCH = STATE_W'(8);
    localparam logic [STATE_W-1:0] JUMP   = STATE_W'(9);
    localparam logic [STATE_W-1:0] IEXEC  = STATE_W'(10);
    localparam logic [STATE_W-1:0] IWB    = STATE_W'(11);
    localparam logic [STATE_W-1:0] ILL    = STATE_W'(12);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   retired_q;
    logic               retire_en;
    logic               pc_write;
    logic               pc_write_cond;
    logic               is_bne;

    assign is_bne = (bus.opcode == OP_BNE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                         state_d = EXEC;
                    OP_LW, OP_SW:                     state_d = MEMADR;
                    OP_BEQ, OP_BNE:                   state_d = BRANCH;
                    OP_J:                             state_d = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEXEC;
                    default:                          state_d = ILL;
                endcase
            end
            MEMADR:  state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXEC:    state_d = RWB;
            IEXEC:   state_d = IWB;
            MEMWB, RWB, IWB, BRANCH, JUMP, ILL: state_d = FETCH;
            // Unused codes recover to FETCH.
            default: state_d = FETCH;
        endcase
    end

    // Instructions retire on leaving their final state; a stalled store
    // retires only on the cycle its write completes. ILL never retires.
    always_comb begin
        retire_en = 1'b0;
        case (state_q)
            MEMWB, RWB, IWB, BRANCH, JUMP: retire_en = 1'b1;
            MEMWR:                         retire_en = bus.mem_ready;
            default:                       retire_en = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: Moore on state, except the FETCH enables which wait
    // for the memory to return the instruction.
    // ------------------------------------------------------------------
    always_comb begin
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegDst    = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        bus.PCSource  = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                pc_write    = bus.mem_ready;
            end
            DECODE: begin
                // Branch target computed speculatively into ALUOut.
                bus.ALUSrcB = 2'b11;
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEMWB: begin
                bus.RegDst   = 1'b1;
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            RWB: begin
                bus.RegWrite = 1'b1;
            end
            IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = 2'b11;
            end
            IWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUOp     = 2'b01;
                bus.PCSource  = 2'b01;
                pc_write_cond = 1'b1;
            end
            JUMP: begin
                pc_write     = 1'b1;
                bus.PCSource = 2'b10;
            end
            ILL: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // bne inverts the sense of the zero flag.
    assign bus.pc_en = pc_write | (pc_write_cond & (bus.zero ^ is_bne));

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_en) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    logic        clk;
    logic        rst;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] retired;
    int          tests;
    int          fails;
    int          ncyc;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .STATE_W(4),
        .CNT_W  (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.master),
        .illegal(illegal),
        .state  (state),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [14:0] ctl();
        return {bus.pc_en, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource};
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state); end
        tests++; if (retired !== 32'd0) begin fails++; $display("FAIL reset_retired got %0d exp 0", retired); end
        tests++; if (ctl() !== 15'b001000000_01_00_00) begin fails++; $display("FAIL reset_fetch_ctl got %b exp %b", ctl(), 15'b001000000_01_00_00); end
        // No memory response: FETCH must hold with IRWrite/pc_en low.
        step();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL fetch_hold got %0d exp 0", state); end
        tests++; if (ctl() !== 15'b001000000_01_00_00) begin fails++; $display("FAIL fetch_hold_ctl got %b exp %b", ctl(), 15'b001000000_01_00_00); end
    endtask

    task automatic test_rtype();
        bus.opcode = 6'h00; bus.mem_ready = 1'b1;
        #1;
        tests++; if (ctl() !== 15'b101010000_01_00_00) begin fails++; $display("FAIL rtype_fetch_ctl got %b exp %b", ctl(), 15'b101010000_01_00_00); end
        step();
        tests++; if (state !== 4'd1) begin fails++; $display("FAIL rtype_s1 got %0d exp 1", state); end
        tests++; if (ctl() !== 15'b000000000_11_00_00) begin fails++; $display("FAIL rtype_decode_ctl got %b exp %b", ctl(), 15'b000000000_11_00_00); end
        step();
        tests++; if (state !== 4'd6) begin fails++; $display("FAIL rtype_s2 got %0d exp 6", state); end
        tests++; if (ctl() !== 15'b000000001_00_10_00) begin fails++; $display("FAIL rtype_exec_ctl got %b exp %b", ctl(), 15'b000000001_00_10_00); end
        step();
        tests++; if (state !== 4'd7) begin fails++; $display("FAIL rtype_s3 got %0d exp 7", state); end
        tests++; if (ctl() !== 15'b000000010_00_00_00) begin fails++; $display("FAIL rtype_rwb_ctl got %b exp %b", ctl(), 15'b000000010_00_00_00); end
        tests++; if (retired !== 32'd0) begin fails++; $display("FAIL rtype_retired_early got %0d exp 0", retired); end
        step();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL rtype_s4 got %0d exp 0", state); end
        tests++; if (retired !== 32'd1) begin fails++; $display("FAIL rtype_retired got %0d exp 1", retired); end
    endtask

    task automatic test_lw_wait();
        bus.opcode = 6'h23; bus.mem_ready = 1'b1;
        ncyc = 0;
        step(); ncyc++;
        step(); ncyc++;
        tests++; if (state !== 4'd2) begin fails++; $display("FAIL lw_memadr got %0d exp 2", state); end
        tests++; if (ctl() !== 15'b000000001_10_00_00) begin fails++; $display("FAIL lw_memadr_ctl got %b exp %b", ctl(), 15'b000000001_10_00_00); end
        step(); ncyc++;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (state !== 4'd3) begin fails++; $display("FAIL lw_memrd_hold%0d got %0d exp 3", i, state); end
            tests++; if (ctl() !== 15'b011000000_00_00_00) begin fails++; $display("FAIL lw_memrd_ctl%0d got %b exp %b", i, ctl(), 15'b011000000_00_00_00); end
            step(); ncyc++;
        end
        tests++; if (state !== 4'd3) begin fails++; $display("FAIL lw_memrd_last got %0d exp 3", state); end
        bus.mem_ready = 1'b1;
        step(); ncyc++;
        tests++; if (state !== 4'd4) begin fails++; $display("FAIL lw_memwb got %0d exp 4", state); end
        tests++; if (ctl() !== 15'b000001110_00_00_00) begin fails++; $display("FAIL lw_memwb_ctl got %b exp %b", ctl(), 15'b000001110_00_00_00); end
        step(); ncyc++;
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL lw_done got %0d exp 0", state); end
        tests++; if (ncyc !== 8) begin fails++; $display("FAIL lw_cycles got %0d exp 8", ncyc); end
        tests++; if (retired !== 32'd2) begin fails++; $display("FAIL lw_retired got %0d exp 2", retired); end
    endtask

    task automatic test_branch();
        // beq taken
        bus.opcode = 6'h04; bus.zero = 1'b1; bus.mem_ready = 1'b1;
        step(); step();
        tests++; if (state !== 4'd8) begin fails++; $display("FAIL beq_state got %0d exp 8", state); end
        tests++; if (ctl() !== 15'b100000001_00_01_01) begin fails++; $display("FAIL beq_taken_ctl got %b exp %b", ctl(), 15'b100000001_00_01_01); end
        step();
        tests++; if (retired !== 32'd3) begin fails++; $display("FAIL beq_retired got %0d exp 3", retired); end
        // bne with zero=1: not taken
        bus.opcode = 6'h05;
        step(); step();
        tests++; if (ctl() !== 15'b000000001_00_01_01) begin fails++; $display("FAIL bne_nt_ctl got %b exp %b", ctl(), 15'b000000001_00_01_01); end
        // bne with zero=0: taken
        bus.zero = 1'b0;
        #1;
        tests++; if (bus.pc_en !== 1'b1) begin fails++; $display("FAIL bne_taken_pc_en got %b exp 1", bus.pc_en); end
        step();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL bne_done got %0d exp 0", state); end
        tests++; if (retired !== 32'd4) begin fails++; $display("FAIL bne_retired got %0d exp 4", retired); end
    endtask

    task automatic test_imm_jump();
        bus.opcode = 6'h0d; bus.mem_ready = 1'b1;
        step(); step();
        tests++; if (state !== 4'd10) begin fails++; $display("FAIL ori_iexec got %0d exp 10", state); end
        tests++; if (ctl() !== 15'b000000001_10_11_00) begin fails++; $display("FAIL ori_iexec_ctl got %b exp %b", ctl(), 15'b000000001_10_11_00); end
        step();
        tests++; if (ctl() !== 15'b000001010_00_00_00) begin fails++; $display("FAIL ori_iwb_ctl got %b exp %b", ctl(), 15'b000001010_00_00_00); end
        step();
        tests++; if (retired !== 32'd5) begin fails++; $display("FAIL ori_retired got %0d exp 5", retired); end
        bus.opcode = 6'h02;
        step(); step();
        tests++; if (state !== 4'd9) begin fails++; $display("FAIL j_state got %0d exp 9", state); end
        tests++; if (ctl() !== 15'b100000000_00_00_10) begin fails++; $display("FAIL j_ctl got %b exp %b", ctl(), 15'b100000000_00_00_10); end
        step();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL j_done got %0d exp 0", state); end
        tests++; if (retired !== 32'd6) begin fails++; $display("FAIL j_retired got %0d exp 6", retired); end
    endtask

    task automatic test_illegal();
        bus.opcode = 6'h3f; bus.mem_ready = 1'b1;
        step();
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_decode_pulse got %b exp 0", illegal); end
        step();
        tests++; if (state !== 4'd12) begin fails++; $display("FAIL ill_state got %0d exp 12", state); end
        tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL ill_pulse got %b exp 1", illegal); end
        tests++; if (ctl() !== 15'b000000000_00_00_00) begin fails++; $display("FAIL ill_ctl got %b exp 0", ctl()); end
        step();
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_pulse_end got %b exp 0", illegal); end
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL ill_done got %0d exp 0", state); end
        tests++; if (retired !== 32'd6) begin fails++; $display("FAIL ill_retired got %0d exp 6", retired); end
    endtask

    task automatic test_sw_reset();
        // Normal store, no stall: 4 cycles, retires.
        bus.opcode = 6'h2b; bus.mem_ready = 1'b1;
        step(); step(); step();
        tests++; if (state !== 4'd5) begin fails++; $display("FAIL sw_memwr got %0d exp 5", state); end
        tests++; if (ctl() !== 15'b010100000_00_00_00) begin fails++; $display("FAIL sw_memwr_ctl got %b exp %b", ctl(), 15'b010100000_00_00_00); end
        step();
        tests++; if (retired !== 32'd7) begin fails++; $display("FAIL sw_retired got %0d exp 7", retired); end
        // Stalled store, then reset mid-wait.
        step(); step(); step();
        bus.mem_ready = 1'b0;
        step();
        tests++; if (state !== 4'd5) begin fails++; $display("FAIL sw_wait_state got %0d exp 5", state); end
        tests++; if (bus.MemWrite !== 1'b1) begin fails++; $display("FAIL sw_wait_memwrite got %b exp 1", bus.MemWrite); end
        tests++; if (retired !== 32'd7) begin fails++; $display("FAIL sw_wait_retired got %0d exp 7", retired); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL rst_mid_state got %0d exp 0", state); end
        tests++; if (bus.MemWrite !== 1'b0) begin fails++; $display("FAIL rst_mid_memwrite got %b exp 0", bus.MemWrite); end
        tests++; if (retired !== 32'd0) begin fails++; $display("FAIL rst_mid_retired got %0d exp 0", retired); end
    endtask

    task automatic test_wrap();
        bus.mem_ready = 1'b0; bus.opcode = 6'h02;
        force dut.retired_q = 32'hffff_ffff;
        step();
        release dut.retired_q;
        step();
        tests++; if (retired !== 32'hffff_ffff) begin fails++; $display("FAIL wrap_preload got %h exp ffffffff", retired); end
        bus.mem_ready = 1'b1;
        step(); step(); step();
        tests++; if (retired !== 32'd0) begin fails++; $display("FAIL wrap_retired got %h exp 0", retired); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_imm_jump();
        test_illegal();
        test_sw_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
